// File: rtl/alu_pkg.sv
// Shared constants and entry layout for the ALU result stage.
package alu_pkg;

    localparam int ALU_N     = 32;
    localparam int ALU_TAG_W = 4;

    localparam logic [1:0] FN_SHIFT = 2'b00;
    localparam logic [1:0] FN_SLT   = 2'b01;
    localparam logic [1:0] FN_ARITH = 2'b10;
    localparam logic [1:0] FN_LOGIC = 2'b11;

    localparam logic [1:0] SLT_SIGNED   = 2'b00;
    localparam logic [1:0] SLT_UNSIGNED = 2'b01;

    // Queue entry, MSB first; the top packs its FIFO word in this same order.
    typedef struct packed {
        logic [ALU_N-1:0]     result;
        logic                 zero;
        logic                 ovf;
        logic                 cout;
        logic [ALU_TAG_W-1:0] tag;
    } entry_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Generic DEPTH x W circular FIFO with occupancy count; storage is not reset.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Captures ALU results (resolving set-less locally) into a writeback FIFO.
// Optional sticky overflow flag: define ALU_RESULT_STICKY_OVF_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_fn_class,
    input  logic [1:0]             in_opcode,
    input  logic [N-1:0]           in_a,
    input  logic [N-1:0]           in_b,
    input  logic [N-1:0]           in_out,
    input  logic                   in_ovf,
    input  logic                   in_cout,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_result,
    output logic                   out_zero,
    output logic                   out_ovf,
    output logic                   out_cout,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf_sticky,
    input  logic                   sticky_clr
);

    localparam int W = N + 3 + TAG_W;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // ready never depends on valid, and a held valid is retried until taken.
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [N:0]       slt_diff;
    logic [N-1:0]     f_result;
    logic             f_zero;
    logic             f_ovf;
    logic             f_cout;
    logic [W-1:0]     rd_data;
    logic [N-1:0]     h_result;
    logic             h_zero;
    logic             h_ovf;
    logic             h_cout;
    logic [TAG_W-1:0] h_tag;

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // N+1-bit subtract: bit N is the borrow (unsigned) or the true sign (signed).
    always_comb begin
        slt_diff = '0;
        f_result = '0;
        f_ovf    = 1'b0;
        f_cout   = 1'b0;
        if (in_opcode == SLT_UNSIGNED) begin
            slt_diff = {1'b0, in_a} - {1'b0, in_b};
        end else begin
            slt_diff = {in_a[N-1], in_a} - {in_b[N-1], in_b};
        end
        case (in_fn_class)
            FN_SLT:   f_result = {{(N-1){1'b0}}, slt_diff[N]};
            FN_ARITH: begin
                f_result = in_out;
                f_ovf    = in_ovf;
                f_cout   = in_cout;
            end
            FN_SHIFT, FN_LOGIC: f_result = in_out;
        endcase
    end

    assign f_zero = (f_result == '0);

    alu_result_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data ({f_result, f_zero, f_ovf, f_cout, in_tag}),
        .rd_data (rd_data),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    assign {h_result, h_zero, h_ovf, h_cout, h_tag} = rd_data;

    // Stale storage is never exposed while the queue is empty.
    assign out_result = out_valid ? h_result : '0;
    assign out_zero   = out_valid ? h_zero   : 1'b0;
    assign out_ovf    = out_valid ? h_ovf    : 1'b0;
    assign out_cout   = out_valid ? h_cout   : 1'b0;
    assign out_tag    = out_valid ? h_tag    : '0;

`ifdef ALU_RESULT_STICKY_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
        end else if (push && f_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (sticky_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign ovf_sticky        = 1'b0;
`endif

endmodule
